comb_decimator: RTL and testbench
=================================

COMB_DECIMATOR -- requirements
Module: comb_decimator

Interface
REQ-001 SHALL have parameter IW, default 8, meaning input/internal comb width in bits (two's complement).
REQ-002 SHALL have parameter OW, default 8, meaning output width, 1 <= OW <= IW.
REQ-003 SHALL have parameter R, default 4, meaning decimation ratio, R >= 1.
REQ-004 SHALL have parameter NSTAGES, default 1, meaning number of comb stages, 1..4.
REQ-005 SHALL have parameter M, default 1, meaning differential delay in decimated samples, 1..2.
REQ-006 SHALL have port i_clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-008 SHALL have port i_data, input, IW bits, signed, meaning integrator-chain output sample.
REQ-009 SHALL have port i_ready, input, 1 bit, meaning i_data valid this cycle (integrator o_ready).
REQ-010 SHALL have port o_data, output, OW bits, signed, meaning filtered decimated sample.
REQ-011 SHALL have port o_ready, output, 1 bit, meaning one-cycle pulse marking o_data updated.

Function
REQ-012 SHALL keep a decimation counter 0..R-1 that increments only on cycles with i_ready=1 and wraps from R-1 to 0.
REQ-013 SHALL accept i_data into comb stage 1 (decimated strobe) only on a cycle with i_ready=1 and counter=R-1; all other samples are discarded.
REQ-014 SHALL, for R=1, accept every i_ready sample.
REQ-015 SHALL register each comb stage k: on its input-valid, y_k <= x_k - x_k delayed by M of its own valid inputs; delay line shifts only on that valid.
REQ-016 SHALL compute all comb arithmetic modulo 2^IW (wrap-around, no saturation, no width growth).
REQ-017 SHALL propagate a valid bit one stage per clock, giving latency of NSTAGES cycles from the accepting i_ready edge to o_ready=1.
REQ-018 SHALL take o_data from the top OW bits of the final stage result, registered together with o_ready.
REQ-019 SHALL hold o_data unchanged between o_ready pulses; o_ready SHALL be high for exactly one cycle per decimated sample.
REQ-020 SHALL sustain back-to-back decimated strobes every cycle (R=1, i_ready held 1) with no sample loss.
REQ-021 SHALL treat i_data as don't-care when i_ready=0.

Reset
REQ-022 SHALL, while i_rst_n=0, asynchronously force counter=0, all comb delay registers=0, all valid bits=0, o_data=0, o_ready=0.
REQ-023 SHALL, on reset mid-operation, discard any partial decimation count and in-flight samples; first output after release requires R fresh i_ready pulses.
REQ-024 SHALL release reset synchronously to i_clk; first state update on the first rising edge with i_rst_n=1.

Configuration
REQ-025 SHALL, with macro COMB_DECIMATOR_ROUND_EN defined and IW>OW, add 2^(IW-OW-1) modulo 2^IW to the final stage result before taking the top OW bits (round-half-up), with no added latency.
REQ-026 SHALL, without COMB_DECIMATOR_ROUND_EN, or when IW=OW, truncate (top OW bits, no offset).

Verification (IW=8, OW=8, R=4, NSTAGES=1, M=1 unless noted)
REQ-027 SHALL check reset: i_rst_n=0 at arbitrary time -> o_data=0, o_ready=0 immediately, without waiting for a clock edge.
REQ-028 SHALL check ramp: i_ready=1 continuously, i_data=0,1,2,... -> accepted 3,7,11,15; o_ready every 4th cycle, 1 cycle after acceptance; o_data=3,4,4,4.
REQ-029 SHALL check gapped input: i_ready high on alternate cycles -> o_ready once per 4 i_ready pulses, identical o_data sequence to the ramp scenario.
REQ-030 SHALL check wrap-around: accepted samples 100 then -100 -> second o_data = 56 (-200 mod 256).
REQ-031 SHALL check rounding (IW=8, OW=4): final result 0x18 -> o_data=1 without the macro, 2 with COMB_DECIMATOR_ROUND_EN; result 0x17 -> 1 in both.
REQ-032 SHALL check reset mid-operation: reset after 2 i_ready pulses, release -> no o_ready until 4 further pulses; first o_data equals that sample minus 0.

Source files
------------

// File: rtl/comb_decimator.sv
// Decimating comb section of a CIC filter: keeps every R-th valid integrator
// sample and runs it through NSTAGES registered comb stages (y = x - x[n-M]).
// Optional macro COMB_DECIMATOR_ROUND_EN selects round-half-up instead of truncation.
module comb_decimator #(
  parameter int IW      = 8,
  parameter int OW      = 8,
  parameter int R       = 4,
  parameter int NSTAGES = 1,
  parameter int M       = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic signed [IW-1:0] i_data,
  input  logic                 i_ready,
  output logic signed [OW-1:0] o_data,
  output logic                 o_ready
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(R - 1);
  localparam int RSH = (IW > OW) ? (IW - OW - 1) : 0;

`ifdef COMB_DECIMATOR_ROUND_EN
  localparam logic signed [IW-1:0] RND_OFS = (IW > OW) ? (IW'(1) << RSH) : '0;
`else
  localparam logic signed [IW-1:0] RND_OFS = '0;
`endif

  logic [CW-1:0]        cnt_reg;
  logic                 strobe;
  logic signed [IW-1:0] stage_x [NSTAGES];
  logic                 stage_v [NSTAGES];
  logic signed [IW-1:0] last_diff;
  logic signed [IW-1:0] last_rounded;
  logic signed [OW-1:0] o_data_reg;
  logic                 o_ready_reg;

  // Decimation counter advances on every valid input, not on every clock
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else if (i_ready) begin
      cnt_reg <= (cnt_reg == CNT_MAX) ? '0 : cnt_reg + CW'(1);
    end
  end

  assign strobe     = i_ready && (cnt_reg == CNT_MAX);
  assign stage_x[0] = i_data;
  assign stage_v[0] = strobe;

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
      logic signed [IW-1:0] dly_reg [M];
      logic signed [IW-1:0] diff;

      assign diff = stage_x[gi] - dly_reg[M-1];

      // Delay line only shifts on this stage's own valid input
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int j = 0; j < M; j++) begin
            dly_reg[j] <= '0;
          end
        end else if (stage_v[gi]) begin
          dly_reg[0] <= stage_x[gi];
          for (int j = 1; j < M; j++) begin
            dly_reg[j] <= dly_reg[j-1];
          end
        end
      end

      if (gi < NSTAGES - 1) begin : g_mid
        logic signed [IW-1:0] y_reg;
        logic                 v_reg;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            y_reg <= '0;
            v_reg <= 1'b0;
          end else begin
            v_reg <= stage_v[gi];
            if (stage_v[gi]) begin
              y_reg <= diff;
            end
          end
        end

        assign stage_x[gi+1] = y_reg;
        assign stage_v[gi+1] = v_reg;
      end else begin : g_last
        assign last_diff = diff;
      end
    end
  endgenerate

  // The last stage's register doubles as the output register, so rounding
  // adds no latency.
  assign last_rounded = last_diff + RND_OFS;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data_reg  <= '0;
      o_ready_reg <= 1'b0;
    end else begin
      o_ready_reg <= stage_v[NSTAGES-1];
      if (stage_v[NSTAGES-1]) begin
        o_data_reg <= OW'(last_rounded >>> (IW - OW));
      end
    end
  end

  assign o_data  = o_data_reg;
  assign o_ready = o_ready_reg;

endmodule

// File: tb/tb_comb_decimator.sv
// Directed bench for comb_decimator: table-driven vectors on the default
// configuration plus short sequences for reset, rounding and multi-stage combs.
module tb_comb_decimator;

  typedef struct {
    bit         rst_before;
    logic       rdy;
    logic [7:0] din;
    logic       exp_rdy;
    logic [7:0] exp_dout;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       rdy;
  logic [7:0] dout;
  logic       dout_rdy;

  logic [7:0] rnd_din;
  logic       rnd_rdy;
  logic [3:0] rnd_dout;
  logic       rnd_dout_rdy;

  logic [7:0] s2_din;
  logic       s2_rdy;
  logic [7:0] s2_dout;
  logic       s2_dout_rdy;

  vec_t tbl [80];
  int   n_tbl;
  int   n_vec;
  int   n_err;

  comb_decimator #(.IW(8), .OW(8), .R(4), .NSTAGES(1), .M(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_ready(rdy),
    .o_data(dout), .o_ready(dout_rdy)
  );

  comb_decimator #(.IW(8), .OW(4), .R(1), .NSTAGES(1), .M(1)) u_rnd (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(rnd_din), .i_ready(rnd_rdy),
    .o_data(rnd_dout), .o_ready(rnd_dout_rdy)
  );

  comb_decimator #(.IW(8), .OW(8), .R(1), .NSTAGES(2), .M(2)) u_s2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(s2_din), .i_ready(s2_rdy),
    .o_data(s2_dout), .o_ready(s2_dout_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(bit rb, logic r, logic [7:0] d, logic er, logic [7:0] ed);
    tbl[n_tbl] = '{rb, r, d, er, ed};
    n_tbl++;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Inputs are driven at the falling edge; outputs are read at the next one.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(logic r, logic [7:0] d);
    rdy = r;
    din = d;
    tick();
  endtask

  // Reset asserted mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    rdy = 1'b0; rnd_rdy = 1'b0; s2_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_o_ready", {7'd0, dout_rdy}, 8'd0);
    chk("async_rst_o_data", dout, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_tbl = 0;
    rst_n = 1'b0; rdy = 1'b0; din = '0;
    rnd_rdy = 1'b0; rnd_din = '0; s2_rdy = 1'b0; s2_din = '0;

    // Ramp, i_ready continuous: accepted 3,7,11,15 -> 3,4,4,4
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b1, 8'(i), (i % 4) == 3, (i < 3) ? 8'd0 : (i < 7) ? 8'd3 : 8'd4);
    // Same ramp with i_ready on alternate cycles and junk data in the gaps
    for (int j = 0; j < 32; j++)
      add(j == 0, j[0], j[0] ? 8'((j - 1) / 2) : 8'hA5, (j % 8) == 7,
          (j < 7) ? 8'd0 : (j < 15) ? 8'd3 : 8'd4);
    // Wrap-around: 100 then -100 -> 100, 56; then hold across an idle cycle
    add(1'b1, 1'b1, 8'd0,   1'b0, 8'd0);
    add(1'b0, 1'b1, 8'd0,   1'b0, 8'd0);
    add(1'b0, 1'b1, 8'd0,   1'b0, 8'd0);
    add(1'b0, 1'b1, 8'd100, 1'b1, 8'd100);
    add(1'b0, 1'b1, 8'd1,   1'b0, 8'd100);
    add(1'b0, 1'b1, 8'd2,   1'b0, 8'd100);
    add(1'b0, 1'b1, 8'd3,   1'b0, 8'd100);
    add(1'b0, 1'b1, 8'd156, 1'b1, 8'd56);
    add(1'b0, 1'b0, 8'd77,  1'b0, 8'd56);
    add(1'b0, 1'b0, 8'd90,  1'b0, 8'd56);

    repeat (2) @(negedge clk);
    chk("por_o_ready", {7'd0, dout_rdy}, 8'd0);
    chk("por_o_data", dout, 8'd0);
    rst_n = 1'b1;

    for (int k = 0; k < n_tbl; k++) begin
      if (tbl[k].rst_before) do_reset();
      step(tbl[k].rdy, tbl[k].din);
      chk($sformatf("vec%0d_o_ready", k), {7'd0, dout_rdy}, {7'd0, tbl[k].exp_rdy});
      chk($sformatf("vec%0d_o_data", k), dout, tbl[k].exp_dout);
    end

    // Reset mid-operation: delay line and partial count must both be dropped
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'd50);
    chk("pre_rst_accept", dout, 8'd50);
    step(1'b1, 8'd9);
    step(1'b1, 8'd9);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(20 + i));
      chk($sformatf("post_rst_quiet%0d", i), {7'd0, dout_rdy}, 8'd0);
    end
    step(1'b1, 8'd23);
    chk("post_rst_o_ready", {7'd0, dout_rdy}, 8'd1);
    chk("post_rst_o_data", dout, 8'd23);
    step(1'b0, 8'd0);
    chk("post_rst_pulse_end", {7'd0, dout_rdy}, 8'd0);

    // OW=4, R=1: result 0x18 then 0x17, back to back
    do_reset();
    rnd_rdy = 1'b1; rnd_din = 8'h18;
    tick();
    chk("rnd_18_o_ready", {7'd0, rnd_dout_rdy}, 8'd1);
`ifdef COMB_DECIMATOR_ROUND_EN
    chk("rnd_18_o_data", {4'd0, rnd_dout}, 8'd2);
`else
    chk("rnd_18_o_data", {4'd0, rnd_dout}, 8'd1);
`endif
    rnd_din = 8'h2F;
    tick();
    chk("rnd_17_o_ready", {7'd0, rnd_dout_rdy}, 8'd1);
    chk("rnd_17_o_data", {4'd0, rnd_dout}, 8'd1);
    rnd_rdy = 1'b0; rnd_din = 8'hFF;
    tick();
    chk("rnd_idle_o_ready", {7'd0, rnd_dout_rdy}, 8'd0);
    chk("rnd_idle_o_data", {4'd0, rnd_dout}, 8'd1);

    // NSTAGES=2, M=2, R=1: x=5,1,7,2 -> y1=5,1,2,1 -> y2=5,1,-3,0, two-cycle latency
    do_reset();
    s2_rdy = 1'b1;
    s2_din = 8'd5; tick();
    chk("s2_lat_o_ready", {7'd0, s2_dout_rdy}, 8'd0);
    s2_din = 8'd1; tick();
    chk("s2_y0_o_ready", {7'd0, s2_dout_rdy}, 8'd1);
    chk("s2_y0", s2_dout, 8'd5);
    s2_din = 8'd7; tick();
    chk("s2_y1", s2_dout, 8'd1);
    s2_din = 8'd2; tick();
    chk("s2_y2", s2_dout, 8'd253);
    s2_rdy = 1'b0; s2_din = 8'h33; tick();
    chk("s2_y3_o_ready", {7'd0, s2_dout_rdy}, 8'd1);
    chk("s2_y3", s2_dout, 8'd0);
    tick();
    chk("s2_drain_o_ready", {7'd0, s2_dout_rdy}, 8'd0);
    chk("s2_hold", s2_dout, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
